// File: rtl/adc_capture_avg.sv
// adc_capture_avg
// Captures ADC samples on each rising edge of the conversion controller's
// output-enable strobe and averages fixed windows of N = 2^AVG_LOG2 samples.
// Averages go to the PID stage through a valid/ready register. A completed
// average that cannot be delivered is dropped, and the sticky overrun flag
// records the drop.
//
// Build option:
//   ADC_CAPTURE_ROUND_EN  defined   -> average rounds half up
//                         undefined -> average is truncated (default)

module adc_capture_avg #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                oe,
  input  logic [DATA_W-1:0]   adc_data,
  output logic [DATA_W-1:0]   sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic [AVG_LOG2:0]   sample_cnt
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(1 << AVG_LOG2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef ADC_CAPTURE_ROUND_EN
  // Half of one output LSB, expressed in accumulator units (0 when N = 1)
  localparam logic [ACC_W-1:0] ROUND_BIAS = ACC_W'((1 << AVG_LOG2) >> 1);
`endif

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;

  logic               oe_d;
  logic               capture;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sample_ext;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               window_full;
  logic               win_done;
  logic [DATA_W-1:0]  avg;

  // Only the rising edge of oe counts, so a strobe held high captures once
  assign capture     = oe & ~oe_d & enable;
  assign sample_ext  = ACC_W'(adc_data);
  assign cnt_inc     = cnt + CNT_ONE;
  assign window_full = (cnt_inc == N_CNT);
  assign sample_cnt  = cnt;

  // Delayed copy of oe for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_d <= 1'b0;
    end else begin
      oe_d <= oe;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: DONE lasts one cycle unless a one-sample window completes again
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (capture && window_full) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (capture && (N_CNT == CNT_ONE)) begin
            state_next = DONE;
          end else begin
            state_next = ACCUM;
          end
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  // FSM outputs: DONE means the accumulator holds a complete window
  always_comb begin
    win_done = 1'b0;
    if (state == DONE) begin
      win_done = 1'b1;
    end
  end

  // Accumulator and sample counter; a capture during DONE starts the next window
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (!enable) begin
      acc <= '0;
      cnt <= '0;
    end else if (win_done) begin
      if (capture) begin
        acc <= sample_ext;
        cnt <= CNT_ONE;
      end else begin
        acc <= '0;
        cnt <= '0;
      end
    end else if (capture) begin
      acc <= acc + sample_ext;
      cnt <= cnt_inc;
    end
  end

  // Window average; the accumulator width guarantees the result fits DATA_W
  always_comb begin
`ifdef ADC_CAPTURE_ROUND_EN
    avg = DATA_W'((acc + ROUND_BIAS) >> AVG_LOG2);
`else
    avg = DATA_W'(acc >> AVG_LOG2);
`endif
  end

  // Output register: load when free or draining this cycle, otherwise drop and flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (win_done) begin
      if (!sample_valid || sample_ready) begin
        sample_data  <= avg;
        sample_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_capture_avg.sv
// tb_adc_capture_avg
// Self-checking bench for adc_capture_avg: a table of directed windows,
// hand-written multi-cycle corner sequences, and a randomized run compared
// against a window-level reference model. Honours ADC_CAPTURE_ROUND_EN.

module tb_adc_capture_avg;

  localparam int DATA_W   = 8;
  localparam int AVG_LOG2 = 2;
  localparam int N        = 1 << AVG_LOG2;

`ifdef ADC_CAPTURE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic                oe;
  logic [DATA_W-1:0]   adc_data;
  logic [DATA_W-1:0]   sample_data;
  logic                sample_valid;
  logic                sample_ready;
  logic                overrun;
  logic [AVG_LOG2:0]   sample_cnt;

  int checks = 0;
  int errors = 0;

  adc_capture_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .oe           (oe),
    .adc_data     (adc_data),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .sample_cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  // Average of a window sum, from the arithmetic definition
  function automatic int avgOf(input int sum);
    if (ROUND && AVG_LOG2 > 0) return (sum + N / 2) / N;
    return sum / N;
  endfunction

  // Reference model: keeps the current window as a list of captured samples
  int  win[$];
  bit  m_oe_prev;
  bit  m_pend;
  int  m_pend_avg;
  bit  m_valid;
  int  m_data;
  bit  m_ovr;
  int  m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      win.delete();
      m_oe_prev = 0;
      m_pend    = 0;
      m_valid   = 0;
      m_data    = 0;
      m_ovr     = 0;
      m_cnt     = 0;
    end else begin
      if (m_pend) begin
        if (!m_valid || sample_ready) begin
          m_data  = m_pend_avg;
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && sample_ready) begin
        m_valid = 0;
      end
      m_pend = 0;
      if (!enable) begin
        win.delete();
        m_cnt = 0;
      end else if (oe && !m_oe_prev) begin
        int sum;
        win.push_back(int'(adc_data));
        if (win.size() == N) begin
          sum = 0;
          foreach (win[i]) sum += win[i];
          m_pend_avg = avgOf(sum);
          m_pend     = 1;
          m_cnt      = N;
          win.delete();
        end else begin
          m_cnt = win.size();
        end
      end else begin
        m_cnt = win.size();
      end
      m_oe_prev = oe;
    end
  end

  typedef struct {
    bit  oe;
    int  data;
    bit  expValid;
    int  expData;
    int  expCnt;
  } vec_t;

  vec_t vecs[$];
  int   heldAvg = 0;

  // One window of four single-cycle oe pulses with ready held high
  function automatic void addWindow(input int d0, input int d1, input int d2,
                                    input int d3, input int avg);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++) begin
      vecs.push_back('{1'b1, d[k], 1'b0, heldAvg, k + 1});
      if (k < 3) vecs.push_back('{1'b0, 0, 1'b0, heldAvg, k + 1});
      else       vecs.push_back('{1'b0, 0, 1'b1, avg, 0});
    end
    vecs.push_back('{1'b0, 0, 1'b0, avg, 0});
    heldAvg = avg;
  endfunction

  task automatic applyStimulus(input bit r, input bit en, input bit o,
                               input int d, input bit rdy);
    rst          = r;
    enable       = en;
    oe           = o;
    adc_data     = DATA_W'(d);
    sample_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int d, input bit rdy);
    applyStimulus(0, 1, 1, d, rdy);
    applyStimulus(0, 1, 0, 0, rdy);
  endtask

  task automatic doReset();
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);
  endtask

  initial begin
    int found;

    rst = 1; enable = 0; oe = 0; adc_data = '0; sample_ready = 0;
    #1;
    doReset();
    checkOutput("reset_valid", int'(sample_valid), 0);
    checkOutput("reset_data", int'(sample_data), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    checkOutput("reset_cnt", int'(sample_cnt), 0);

    // Directed windows: sums 101, 41, 6
    addWindow(10, 20, 30, 41, 25);
    addWindow(10, 10, 10, 11, 10);
    addWindow(1, 1, 1, 3, ROUND ? 2 : 1);
    foreach (vecs[i]) begin
      applyStimulus(0, 1, vecs[i].oe, vecs[i].data, 1);
      checkOutput($sformatf("vec%0d_valid", i), int'(sample_valid), int'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_data", i), int'(sample_data), vecs[i].expData);
      checkOutput($sformatf("vec%0d_cnt", i), int'(sample_cnt), vecs[i].expCnt);
      checkOutput($sformatf("vec%0d_overrun", i), int'(overrun), 0);
    end

    // oe held high for five cycles captures exactly once
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 200, 1);
    checkOutput("held_oe_cnt", int'(sample_cnt), 1);
    applyStimulus(0, 1, 0, 0, 1);

    // Backpressure: second average dropped, overrun sticky after handshake
    doReset();
    for (int i = 0; i < 8; i++) pulse(8'h40, 0);
    checkOutput("ovr_valid_held", int'(sample_valid), 1);
    checkOutput("ovr_data_held", int'(sample_data), 8'h40);
    checkOutput("ovr_flag_set", int'(overrun), 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("ovr_valid_drop", int'(sample_valid), 0);
    checkOutput("ovr_flag_sticky", int'(overrun), 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("ovr_no_second", int'(sample_valid), 0);

    // enable low abandons a partial window
    doReset();
    pulse(77, 1);
    pulse(77, 1);
    checkOutput("en_cnt_partial", int'(sample_cnt), 2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("en_cnt_cleared", int'(sample_cnt), 0);
    for (int i = 0; i < 4; i++) pulse(8, 1);
    checkOutput("en_valid", int'(sample_valid), 1);
    checkOutput("en_data", int'(sample_data), 8);

    // Reset mid-window with a pending output
    doReset();
    for (int i = 0; i < 4; i++) pulse(50, 0);
    for (int i = 0; i < 3; i++) pulse(9, 0);
    checkOutput("rst_pre_valid", int'(sample_valid), 1);
    checkOutput("rst_pre_cnt", int'(sample_cnt), 3);
    applyStimulus(1, 1, 1, 9, 0);
    checkOutput("rst_valid", int'(sample_valid), 0);
    checkOutput("rst_data", int'(sample_data), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_cnt", int'(sample_cnt), 0);
    applyStimulus(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) pulse(100, 1);
    applyStimulus(0, 1, 1, 100, 1);
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (sample_valid) found = 1;
    end
    checkOutput("rst_after_valid_seen", found, 1);
    checkOutput("rst_after_data", int'(sample_data), 100);

    // Next capture right behind a completed window lands in the new window
    doReset();
    pulse(4, 1); pulse(8, 1); pulse(12, 1);
    applyStimulus(0, 1, 1, 16, 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("b2b_valid", int'(sample_valid), 1);
    checkOutput("b2b_data", int'(sample_data), 10);
    applyStimulus(0, 1, 1, 33, 1);
    checkOutput("b2b_cnt", int'(sample_cnt), 1);
    checkOutput("b2b_valid_drop", int'(sample_valid), 0);

    // Randomized run against the reference model
    doReset();
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 499) == 0),
                    ($urandom_range(0, 39) != 0),
                    $urandom_range(0, 1),
                    $urandom_range(0, 255),
                    ($urandom_range(0, 3) != 0));
      checkOutput($sformatf("rnd%0d_valid", i), int'(sample_valid), int'(m_valid));
      checkOutput($sformatf("rnd%0d_data", i), int'(sample_data), m_data);
      checkOutput($sformatf("rnd%0d_overrun", i), int'(overrun), int'(m_ovr));
      checkOutput($sformatf("rnd%0d_cnt", i), int'(sample_cnt), m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
